// File: rtl/tia_cpu_clock_sequencer.sv
// CPU phase clock and horizontal line timing for the TIA core.
// Owns the phi0 phase, the line position and the WSYNC halt of the CPU.
module tia_cpu_clock_sequencer #(
  parameter int LINE_CLOCKS = 228,
  parameter int HBLANK_END  = 68,
  parameter int HSYNC_START = 16,
  parameter int HSYNC_END   = 32
) (
  input  logic       clk,
  input  logic       resphi0,
  input  logic       wsync,
  input  logic       rsync,
  output logic       phi0,
  output logic       phi0_en,
  output logic       rdy,
  output logic [7:0] hcount,
  output logic       hblank,
  output logic       hsync,
  output logic       line_start
);

  localparam logic [7:0] LAST_CLOCK    = 8'(LINE_CLOCKS - 1);
  localparam logic [7:0] HBLANK_LIMIT  = 8'(HBLANK_END);
  localparam logic [7:0] HSYNC_FIRST   = 8'(HSYNC_START);
  localparam logic [7:0] HSYNC_LIMIT   = 8'(HSYNC_END);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] phase;
  logic [1:0] phase_next;
  logic [7:0] hcount_next;
  logic       wsync_hit;
  logic       rsync_hit;

  // Strobes only count in the phi0_en cycle, when the CPU write is valid.
  assign wsync_hit = wsync & phi0_en;
  assign rsync_hit = rsync & phi0_en;

  always_comb begin
    phase_next = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
  end

  always_comb begin
    hcount_next = hcount + 8'd1;
    if (rsync_hit || (hcount == LAST_CLOCK)) begin
      hcount_next = 8'd0;
    end
  end

  // A simultaneous RSYNC discards WSYNC; a halt ends whenever the line restarts.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (wsync_hit && !rsync_hit) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (hcount_next == 8'd0) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge resphi0) begin
    if (resphi0) begin
      phase  <= 2'd0;
      hcount <= 8'd0;
      state  <= RUN;
    end else begin
      phase  <= phase_next;
      hcount <= hcount_next;
      state  <= state_next;
    end
  end

  assign phi0       = (phase != 2'd2);
  assign phi0_en    = (phase == 2'd2);
  assign rdy        = (state == RUN);
  assign hblank     = (hcount < HBLANK_LIMIT);
  assign hsync      = (hcount >= HSYNC_FIRST) && (hcount < HSYNC_LIMIT);
  assign line_start = (hcount == 8'd0);

endmodule

// File: tb/tb_tia_cpu_clock_sequencer.sv
// Self-checking bench for tia_cpu_clock_sequencer: reset vectors, a directed
// table from reset, and model-scored runs through the WSYNC/RSYNC corner cases.
module tb_tia_cpu_clock_sequencer;

  logic       clk = 1'b0;
  logic       resphi0 = 1'b1;
  logic       wsync = 1'b0;
  logic       rsync = 1'b0;
  logic       phi0;
  logic       phi0_en;
  logic       rdy;
  logic [7:0] hcount;
  logic       hblank;
  logic       hsync;
  logic       line_start;

  tia_cpu_clock_sequencer dut (
    .clk        (clk),
    .resphi0    (resphi0),
    .wsync      (wsync),
    .rsync      (rsync),
    .phi0       (phi0),
    .phi0_en    (phi0_en),
    .rdy        (rdy),
    .hcount     (hcount),
    .hblank     (hblank),
    .hsync      (hsync),
    .line_start (line_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       phi0;
    logic       phi0_en;
    logic       rdy;
    logic [7:0] hcount;
    logic       hblank;
    logic       hsync;
    logic       line_start;
  } out_t;

  typedef struct {
    logic       w;
    logic       r;
    logic       phi0;
    logic       phi0_en;
    logic       rdy;
    logic [7:0] hcount;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail = 0;

  int   m_phase = 0;
  int   m_h = 0;
  bit   m_halt = 1'b0;

  function automatic out_t expect_from(input logic ph0, input logic en,
                                       input logic rd, input logic [7:0] h);
    out_t e;
    e.phi0       = ph0;
    e.phi0_en    = en;
    e.rdy        = rd;
    e.hcount     = h;
    e.hblank     = (h < 8'd68);
    e.hsync      = (h >= 8'd16) && (h < 8'd32);
    e.line_start = (h == 8'd0);
    return e;
  endfunction

  function automatic out_t model_out();
    return expect_from(m_phase != 2, m_phase == 2, !m_halt, 8'(m_h));
  endfunction

  // Reference behaviour: one clk edge with the given strobes.
  task automatic model_step(input logic w, input logic r);
    bit en;
    bit hw;
    bit hr;
    en = (m_phase == 2);
    hw = w && en;
    hr = r && en;
    if (hr || m_h == 227) m_h = 0;
    else m_h = m_h + 1;
    if (!m_halt) m_halt = hw && !hr;
    else m_halt = (m_h != 0);
    m_phase = (m_phase + 1) % 3;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_h = 0;
    m_halt = 1'b0;
  endtask

  task automatic check_output(input string name);
    out_t act;
    out_t e;
    act = '{phi0, phi0_en, rdy, hcount, hblank, hsync, line_start};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s: no expected entry queued, actual=%h", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: actual phi0=%b en=%b rdy=%b hcount=%0d hblank=%b hsync=%b line_start=%b, required phi0=%b en=%b rdy=%b hcount=%0d hblank=%b hsync=%b line_start=%b",
               name, act.phi0, act.phi0_en, act.rdy, act.hcount, act.hblank, act.hsync,
               act.line_start, e.phi0, e.phi0_en, e.rdy, e.hcount, e.hblank, e.hsync,
               e.line_start);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic w, input logic r,
                                input bit use_vec, input out_t vec_exp);
    model_step(w, r);
    exp_q.push_back(use_vec ? vec_exp : model_out());
    wsync = w;
    rsync = r;
    @(posedge clk);
    #1;
    check_output(name);
  endtask

  task automatic run_free(input string name, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(name, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic advance_to_enable(input int target);
    for (int i = 0; i < 700 && !(m_h >= target && m_phase == 2); i++)
      apply_stimulus("approach", 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Asserts reset between edges, checks the async reset values, releases after an edge.
  task automatic do_reset(input string name);
    #2;
    resphi0 = 1'b1;
    #1;
    exp_q.push_back(expect_from(1'b1, 1'b0, 1'b1, 8'd0));
    check_output(name);
    @(posedge clk);
    #1;
    wsync = 1'b0;
    rsync = 1'b0;
    resphi0 = 1'b0;
    model_reset();
  endtask

  initial begin
    int count;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};

    repeat (2) @(posedge clk);
    do_reset("reset_values");

    for (int i = 0; i < 10; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i].w, vecs[i].r, 1'b1,
                     expect_from(vecs[i].phi0, vecs[i].phi0_en, vecs[i].rdy, vecs[i].hcount));

    do_reset("reset_after_table");
    count = 0;
    for (int i = 0; i < 456; i++) begin
      apply_stimulus("free_run", 1'b0, 1'b0, 1'b0, '0);
      if (line_start === 1'b1) count++;
    end
    n_checks++;
    if (count != 2) begin
      n_fail++;
      $display("[TB] FAIL line_start_count: actual %0d, required 2", count);
    end

    apply_stimulus("wsync_no_en", 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus("rsync_no_en", 1'b0, 1'b1, 1'b0, '0);

    advance_to_enable(98);
    apply_stimulus("wsync_mid_line", 1'b1, 1'b0, 1'b0, '0);
    run_free("halted_line", 135);

    advance_to_enable(149);
    apply_stimulus("rsync_mid_line", 1'b0, 1'b1, 1'b0, '0);
    run_free("after_rsync", 6);

    advance_to_enable(60);
    apply_stimulus("wsync_rsync_together", 1'b1, 1'b1, 1'b0, '0);
    run_free("after_together", 5);

    advance_to_enable(227);
    apply_stimulus("wsync_at_last", 1'b1, 1'b0, 1'b0, '0);
    count = (rdy === 1'b0) ? 1 : 0;
    for (int i = 0; i < 230; i++) begin
      apply_stimulus("full_line_halt", 1'b0, 1'b0, 1'b0, '0);
      if (rdy === 1'b0) count++;
    end
    n_checks++;
    if (count != 228) begin
      n_fail++;
      $display("[TB] FAIL halt_length: actual %0d rdy-low clocks, required 228", count);
    end

    advance_to_enable(20);
    apply_stimulus("wsync_before_reset", 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 300 && m_h != 50; i++)
      apply_stimulus("halted_to_50", 1'b0, 1'b0, 1'b0, '0);
    do_reset("async_reset_mid_halt");
    run_free("post_reset", 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
